// File: rtl/mul_seq_unit_if.sv
// Request/response bundle between the Execute stage and the sequential
// multiplier. The requester drives the master side and the unit drives the slave side.
interface mul_seq_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        funct3;
  logic [4:0]        rd_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [4:0]        rd_out;

  modport master (
    output start, a, b, funct3, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, a, b, funct3, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// The multiply runs on operand magnitudes with a shift-add loop, and the sign is
// applied once at the end. Optional macro MUL_RADIX4_EN retires two multiplier
// bits per cycle (16 iterations) in place of one (32 iterations). Results are
// the same in both builds.
module mul_seq_unit #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_seq_unit_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
`ifdef MUL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int ITERS = DATA_W / STEP;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic              last_iter;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_next;
  logic [PROD_W-1:0] addend;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic              neg;
  logic              hi_sel;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] result_q;
  logic [4:0]        rd_out_q;

  logic                     a_signed;
  logic                     b_signed;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [DATA_W-1:0]        mag_a;
  logic [DATA_W-1:0]        mag_b;

  // Absolute value when the operand is treated as signed, else pass through.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(
    input logic signed [DATA_W-1:0] v,
    input logic                     sgn
  );
    if (sgn && v[DATA_W-1]) magnitude = $unsigned(-v);
    else                    magnitude = $unsigned(v);
  endfunction

  // Apply the final sign to the full product and pick the architectural word.
  function automatic logic [DATA_W-1:0] select_word(
    input logic [PROD_W-1:0] prod,
    input logic              negate,
    input logic              hi
  );
    logic [PROD_W-1:0] p;
    p = negate ? (~prod + PROD_W'(1)) : prod;
    select_word = hi ? p[PROD_W-1:DATA_W] : p[DATA_W-1:0];
  endfunction

  // Operand-signedness decode; reserved 1xx encodings behave as MULHU.
  always_comb begin
    a_signed = !bus.funct3[2] && (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    b_signed = (bus.funct3 == 3'b001);
    a_s      = $signed(bus.a);
    b_s      = $signed(bus.b);
    mag_a    = magnitude(a_s, a_signed);
    mag_b    = magnitude(b_s, b_signed);
  end

  // One shift-add step: add the multiplicand scaled by the low multiplier digit.
  always_comb begin
    addend = '0;
`ifdef MUL_RADIX4_EN
    unique case (mplier[1:0])
      2'b00:   addend = '0;
      2'b01:   addend = mcand;
      2'b10:   addend = mcand << 1;
      default: addend = mcand + (mcand << 1);
    endcase
`else
    if (mplier[0]) addend = mcand;
`endif
    acc_next  = acc + addend;
    last_iter = (cnt == CNT_W'(ITERS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: CALC runs ITERS cycles, DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture operands in IDLE, iterate in CALC, and latch the result on the last step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      hi_sel   <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= (a_signed & bus.a[DATA_W-1]) ^ (b_signed & bus.b[DATA_W-1]);
            hi_sel <= (bus.funct3 != 3'b000);
            rd_q   <= bus.rd_in;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            result_q <= select_word(acc_next, neg, hi_sel);
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed and random bench for mul_seq_unit with a scoreboard queue of
// expected results. Build with MUL_RADIX4_EN for the radix-4 latency.
module tb_mul_seq_unit;

`ifdef MUL_RADIX4_EN
  localparam int EXP_LAT = 17;
`else
  localparam int EXP_LAT = 33;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    string       tag;
  } sb_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   done_cnt;
  sb_t  exp_q[$];

  mul_seq_unit_if bus ();

  mul_seq_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                        input logic [2:0] f);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ua = longint'({32'h0, ia});
    ub = longint'({32'h0, ib});
    case (f)
      3'b000:  p = ua * ub;
      3'b001:  p = sa * sb;
      3'b010:  p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Called at a falling edge with the unit idle; returns at the falling edge of T+1.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] f,
                       input logic [4:0] rd, input logic [31:0] expv, input string tag,
                       input bit push);
    sb_t e;
    bus.start  = 1'b1;
    bus.a      = ia;
    bus.b      = ib;
    bus.funct3 = f;
    bus.rd_in  = rd;
    if (push) begin
      e.res = expv;
      e.rd  = rd;
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = ~ia;
    bus.b      = ~ib;
    bus.funct3 = ~f;
    bus.rd_in  = ~rd;
  endtask

  // Waits (bounded) for done, starting at latency lat0, then checks against the scoreboard.
  task automatic wait_done(input int lat0);
    int  lat;
    sb_t e;
    lat = lat0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    check("latency", 32'(lat), 32'(EXP_LAT));
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_result"}, bus.result, e.res);
      check({e.tag, "_rd"}, 32'(bus.rd_out), 32'(e.rd));
    end
  endtask

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] f,
                        input logic [4:0] rd, input logic [31:0] expv, input string tag);
    issue(ia, ib, f, rd, expv, tag, 1'b1);
    wait_done(1);
    @(negedge clk);
    check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic [4:0]  rr;
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.funct3 = '0;
    bus.rd_in  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", 32'(bus.rd_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op(32'd7, 32'd6, 3'b000, 5'd5, 32'h0000002A, "mul_7x6");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 5'd1, 32'h00000000, "mulh_m1");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 5'd2, 32'hFFFFFFFE, "mulhu_m1");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 5'd3, 32'h00000001, "mul_m1");
    run_op(32'hFFFFFFFE, 32'h00000003, 3'b010, 5'd4, 32'hFFFFFFFF, "mulhsu_m2x3");
    run_op(32'hFFFFFFFE, 32'h00000003, 3'b000, 5'd6, 32'hFFFFFFFA, "mul_m2x3");
    run_op(32'h80000000, 32'h80000000, 3'b001, 5'd7, 32'h40000000, "mulh_min");
    run_op(32'h00000000, 32'h80000000, 3'b001, 5'd8, 32'h00000000, "mulh_zero");
    run_op(32'hDEADBEEF, 32'h00000000, 3'b010, 5'd9, 32'h00000000, "mulhsu_zero");
    run_op(32'h00000000, 32'hFFFFFFFF, 3'b000, 5'd10, 32'h00000000, "mul_zero");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 5'd11, 32'hFFFFFFFE, "rsvd_as_mulhu");

    // Starts while busy (mid-CALC and in DONE) are ignored
    issue(32'd3, 32'd5, 3'b000, 5'd12, 32'd15, "ignore", 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.funct3 = 3'b000; bus.rd_in = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(11);
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1; bus.funct3 = 3'b000; bus.rd_in = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore_busy_fall", 32'(bus.busy), 32'd0);
    check("ignore_hold_result", bus.result, 32'd15);
    check("ignore_hold_rd", 32'(bus.rd_out), 32'd12);
    @(negedge clk);
    check("ignore_still_idle", 32'(bus.busy), 32'd0);

    // Reset mid-CALC aborts the operation
    issue(32'd7, 32'd9, 3'b000, 5'd3, 32'd63, "abort", 1'b0);
    repeat (9) @(negedge clk);
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_rd", 32'(bus.rd_out), 32'd0);
    bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    check("rst_over_start", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    reset = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(32'd11, 32'd13, 3'b000, 5'd14, 32'd143, "post_abort");

    // Random operations against the reference model
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 3'($urandom_range(0, 7));
      rr = 5'($urandom_range(0, 31));
      run_op(ra, rb, rf, rr, model(ra, rb, rf), "rand");
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
